// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for the fetch queue
interface fetch_queue_if #(
  parameter int PTR_W = 3
);
  logic             flush;
  logic             enq_valid;
  logic [31:0]      enq_instruction;
  logic [31:0]      enq_pc;
  logic             enq_ready;
  logic             deq_valid;
  logic [31:0]      deq_instruction;
  logic [31:0]      deq_pc;
  logic             deq_ready;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             fetch_stall;

  modport master (
    output flush, enq_valid, enq_instruction, enq_pc, deq_ready,
    input  enq_ready, deq_valid, deq_instruction, deq_pc, count, full, empty, fetch_stall
  );

  modport slave (
    input  flush, enq_valid, enq_instruction, enq_pc, deq_ready,
    output enq_ready, deq_valid, deq_instruction, deq_pc, count, full, empty, fetch_stall
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FWFT instruction buffer between fetch and decode
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int SKID  = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_queue_if.slave q
);
  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_STALL = (PTR_W+1)'(DEPTH - SKID);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_enq_fire;
  logic w_deq_fire;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // Zero instruction words are fetch bubbles and never occupy an entry.
  assign w_enq_fire = q.enq_valid && !w_full && (q.enq_instruction != 32'd0) && !q.flush;
  assign w_deq_fire = !w_empty && q.deq_ready && !q.flush;

  assign q.enq_ready       = !w_full;
  assign q.deq_valid       = !w_empty;
  assign q.deq_instruction = w_empty ? 32'd0 : r_mem[r_head][31:0];
  assign q.deq_pc          = w_empty ? 32'd0 : r_mem[r_head][63:32];
  assign q.count           = r_count;
  assign q.full            = w_full;
  assign q.empty           = w_empty;
  assign q.fetch_stall     = (r_count >= LP_STALL);

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem[r_tail] <= {q.enq_pc, q.enq_instruction};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (q.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_deq_fire) begin
        r_head <= r_head + 1'b1;
      end
      if (w_enq_fire && !w_deq_fire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq_fire && w_deq_fire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
  logic clk;
  logic reset_n;
  logic chk_en;
  int   n_checks;
  int   n_fail;

  fetch_queue_if #(.PTR_W(3)) fq ();

  fetch_queue #(.DEPTH(8), .PTR_W(3), .SKID(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (fq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: occupancy is simply the list length, capacity 8.
  always @(posedge clk) begin : model
    bit e_fire;
    bit d_fire;
    if (reset_n) begin
      if (fq.flush) begin
        mq.delete();
      end else begin
        e_fire = fq.enq_valid && (mq.size() < 8) && (fq.enq_instruction != 32'd0);
        d_fire = fq.deq_ready && (mq.size() > 0);
        if (d_fire) void'(mq.pop_front());
        if (e_fire) mq.push_back({fq.enq_pc, fq.enq_instruction});
      end
    end
  end

  always @(negedge reset_n) mq.delete();

  always @(negedge clk) begin : compare
    int n;
    if (chk_en) begin
      n = mq.size();
      check("count", 64'(fq.count), 64'(n));
      check("full", 64'(fq.full), 64'(n == 8));
      check("empty", 64'(fq.empty), 64'(n == 0));
      check("enq_ready", 64'(fq.enq_ready), 64'(n < 8));
      check("deq_valid", 64'(fq.deq_valid), 64'(n > 0));
      check("fetch_stall", 64'(fq.fetch_stall), 64'(n >= 7));
      check("deq_entry", {32'(fq.deq_pc), 32'(fq.deq_instruction)}, (n > 0) ? mq[0] : 64'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic ev, input logic [31:0] ins, input logic [31:0] pc, input logic dr, input logic fl);
    fq.enq_valid       = ev;
    fq.enq_instruction = ins;
    fq.enq_pc          = pc;
    fq.deq_ready       = dr;
    fq.flush           = fl;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    reset_n  = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("rst_count", 64'(fq.count), 64'd0);
    check("rst_empty", 64'(fq.empty), 64'd1);
    check("rst_enq_ready", 64'(fq.enq_ready), 64'd1);
    check("rst_deq_instr", 64'(fq.deq_instruction), 64'd0);

    // Fill to full; the ninth word must be refused.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h0010_0093 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
      tick();
      if (i == 6) check("stall_at_7", 64'(fq.fetch_stall), 64'd1);
      if (i == 5) check("no_stall_at_6", 64'(fq.fetch_stall), 64'd0);
    end
    check("full_count", 64'(fq.count), 64'd8);
    check("full_flag", 64'(fq.full), 64'd1);
    check("full_enq_ready", 64'(fq.enq_ready), 64'd0);

    // Drain in order.
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("drain_pc", 64'(fq.deq_pc), 64'(i * 4));
      check("drain_instr", 64'(fq.deq_instruction), 64'(32'h0010_0093 + 32'(i)));
      tick();
    end
    check("drained_empty", 64'(fq.empty), 64'd1);
    check("drained_instr", 64'(fq.deq_instruction), 64'd0);

    // Steady stream: one word in flight, pointers wrap.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(i), 32'h100 + 32'(i * 4), 1'b1, 1'b0);
      tick();
      check("stream_count", 64'(fq.count), 64'd1);
      check("stream_pc", 64'(fq.deq_pc), 64'(32'h100 + 32'(i * 4)));
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    check("stream_empty", 64'(fq.empty), 64'd1);

    // Flush with count=5 and both handshakes active.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000_2000 + 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    check("preflush_count", 64'(fq.count), 64'd5);
    drive(1'b1, 32'h0000_2FFF, 32'h2FC, 1'b1, 1'b1);
    tick();
    check("flush_count", 64'(fq.count), 64'd0);
    check("flush_empty", 64'(fq.empty), 64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("flush_absent", 64'(fq.deq_valid), 64'd0);

    // Bubble between two real words.
    drive(1'b1, 32'h0000_3001, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0000, 32'h304, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_3002, 32'h308, 1'b0, 1'b0);
    tick();
    check("bubble_count", 64'(fq.count), 64'd2);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("bubble_first", 64'(fq.deq_pc), 64'h300);
    tick();
    check("bubble_second", 64'(fq.deq_pc), 64'h308);
    tick();
    check("bubble_drained", 64'(fq.empty), 64'd1);

    // Asynchronous reset with count=4.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_4000 + 32'(i), 32'h400 + 32'(i * 4), 1'b0, 1'b0);
      tick();
    end
    check("prereset_count", 64'(fq.count), 64'd4);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("async_count", 64'(fq.count), 64'd0);
    check("async_empty", 64'(fq.empty), 64'd1);
    check("async_deq_pc", 64'(fq.deq_pc), 64'd0);
    tick();
    reset_n = 1'b1;
    drive(1'b1, 32'h0000_5001, 32'h500, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("post_reset_count", 64'(fq.count), 64'd1);
    check("post_reset_pc", 64'(fq.deq_pc), 64'h500);
    check("post_reset_instr", 64'(fq.deq_instruction), 64'h5001);
    tick();
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
